// File: rtl/reg_bank_param.sv
// reg_bank_param
//   Parametrised register bank: 2**ADDR_W registers of DATA_W bits, one
//   synchronous write port, two registered read ports with write-to-read
//   bypass, an optional hard-wired zero register and a per-register pending
//   scoreboard that flags reads of registers whose producer has not yet
//   written back.
//
// Parameters
//   DATA_W    register / data width
//   ADDR_W    address width, NREG = 2**ADDR_W
//   ZERO_REG  1: register 0 reads 0, ignores writes, never pending
//
// Ports
//   CLK                    clock, rising edge
//   RST_N                  asynchronous active-low reset, clears all state
//   wr_en/wr_addr/wr_data  write port
//   rsv_en/rsv_addr        reserve port (marks a register pending)
//   rd_en_k/rd_addr_k      read request, port k (k = 1, 2)
//   rd_data_k              registered read data
//   rd_valid_k             one-cycle pulse after an accepted read
//   rd_pend_k              returned data is stale (pending, not bypassed)
module reg_bank_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              rd_en_1,
  input  logic [ADDR_W-1:0] rd_addr_1,
  input  logic              rd_en_2,
  input  logic [ADDR_W-1:0] rd_addr_2,
  output logic [DATA_W-1:0] rd_data_1,
  output logic              rd_valid_1,
  output logic              rd_pend_1,
  output logic [DATA_W-1:0] rd_data_2,
  output logic              rd_valid_2,
  output logic              rd_pend_2
);

  localparam int NREG = 2**ADDR_W;

  logic [DATA_W-1:0] regs [NREG];
  logic [NREG-1:0]   pending;

  logic              byp_1_p0;
  logic              byp_2_p0;
  logic [DATA_W-1:0] rd_data_1_p0;
  logic [DATA_W-1:0] rd_data_2_p0;
  logic              rd_pend_1_p0;
  logic              rd_pend_2_p0;

  // Address 0 is the hard-wired zero register when ZERO_REG is set.
  function automatic logic hits_zero(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic is_bypass(input logic              we,
                                     input logic [ADDR_W-1:0] wa,
                                     input logic [ADDR_W-1:0] ra);
    return we && (wa == ra) && !hits_zero(ra);
  endfunction

  // Stage p0: read selection from pre-edge storage/scoreboard and write bus
  always_comb begin
    byp_1_p0     = is_bypass(wr_en, wr_addr, rd_addr_1);
    byp_2_p0     = is_bypass(wr_en, wr_addr, rd_addr_2);
    rd_data_1_p0 = byp_1_p0 ? wr_data : regs[rd_addr_1];
    rd_data_2_p0 = byp_2_p0 ? wr_data : regs[rd_addr_2];
    rd_pend_1_p0 = pending[rd_addr_1] && !byp_1_p0;
    rd_pend_2_p0 = pending[rd_addr_2] && !byp_2_p0;
    if (hits_zero(rd_addr_1)) begin
      rd_data_1_p0 = '0;
      rd_pend_1_p0 = 1'b0;
    end
    if (hits_zero(rd_addr_2)) begin
      rd_data_2_p0 = '0;
      rd_pend_2_p0 = 1'b0;
    end
  end

  // Storage and scoreboard update. The reserve is applied after the write so
  // a same-edge write+reserve leaves the register pending: the reserve
  // belongs to a newer producer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      if (wr_en && !hits_zero(wr_addr)) begin
        regs[wr_addr]    <= wr_data;
        pending[wr_addr] <= 1'b0;
      end
      if (rsv_en && !hits_zero(rsv_addr)) begin
        pending[rsv_addr] <= 1'b1;
      end
    end
  end

  // Stage p1: registered read ports; data/pend hold while not reading
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_data_1  <= '0;
      rd_pend_1  <= 1'b0;
      rd_valid_1 <= 1'b0;
      rd_data_2  <= '0;
      rd_pend_2  <= 1'b0;
      rd_valid_2 <= 1'b0;
    end else begin
      rd_valid_1 <= rd_en_1;
      rd_valid_2 <= rd_en_2;
      if (rd_en_1) begin
        rd_data_1 <= rd_data_1_p0;
        rd_pend_1 <= rd_pend_1_p0;
      end
      if (rd_en_2) begin
        rd_data_2 <= rd_data_2_p0;
        rd_pend_2 <= rd_pend_2_p0;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_param.sv
// Bench for reg_bank_param: drives the same stimulus into a default instance
// (32-bit, 4 regs, no zero register) and a scaled instance (8-bit, 8 regs,
// zero register). Expected read results are queued per port when a read is
// issued; a monitor on the falling edge pops and compares on rd_valid and
// checks that data/pend hold otherwise.
module tb_reg_bank_param;

  typedef struct packed {
    logic [31:0] data;
    logic        pend;
  } exp_t;

  logic        CLK;
  logic        RST_N;
  logic        wr_en, rsv_en, rd_en_1, rd_en_2;
  logic [2:0]  wr_addr, rsv_addr, rd_addr_1, rd_addr_2;
  logic [31:0] wr_data;

  logic [31:0] a_rd_data_1, a_rd_data_2;
  logic        a_rd_valid_1, a_rd_valid_2, a_rd_pend_1, a_rd_pend_2;
  logic [7:0]  b_rd_data_1, b_rd_data_2;
  logic        b_rd_valid_1, b_rd_valid_2, b_rd_pend_1, b_rd_pend_2;

  int total = 0;
  int bad   = 0;
  bit mon_on = 0;

  exp_t q0[$], q1[$], q2[$], q3[$];
  exp_t last_exp [4];

  // Reference state: index 0 = default instance, 1 = scaled instance
  logic [31:0] mreg  [2][8];
  logic        mpend [2][8];

  reg_bank_param dut_a (
    .CLK(CLK), .RST_N(RST_N),
    .wr_en(wr_en), .wr_addr(wr_addr[1:0]), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr[1:0]),
    .rd_en_1(rd_en_1), .rd_addr_1(rd_addr_1[1:0]),
    .rd_en_2(rd_en_2), .rd_addr_2(rd_addr_2[1:0]),
    .rd_data_1(a_rd_data_1), .rd_valid_1(a_rd_valid_1), .rd_pend_1(a_rd_pend_1),
    .rd_data_2(a_rd_data_2), .rd_valid_2(a_rd_valid_2), .rd_pend_2(a_rd_pend_2)
  );

  reg_bank_param #(.DATA_W(8), .ADDR_W(3), .ZERO_REG(1)) dut_b (
    .CLK(CLK), .RST_N(RST_N),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data[7:0]),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .rd_en_1(rd_en_1), .rd_addr_1(rd_addr_1),
    .rd_en_2(rd_en_2), .rd_addr_2(rd_addr_2),
    .rd_data_1(b_rd_data_1), .rd_valid_1(b_rd_valid_1), .rd_pend_1(b_rd_pend_1),
    .rd_data_2(b_rd_data_2), .rd_valid_2(b_rd_valid_2), .rd_pend_2(b_rd_pend_2)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, want, $time);
    end
  endtask

  function automatic int amask(input int d);
    return (d == 0) ? 3 : 7;
  endfunction

  function automatic logic [31:0] dmask(input int d);
    return (d == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  function automatic bit has_zero(input int d);
    return d == 1;
  endfunction

  // Result a read of address ra would return, given the write on the same edge
  function automatic exp_t model_read(input int d, input logic [2:0] ra,
                                      input logic we, input logic [2:0] wa,
                                      input logic [31:0] wd);
    exp_t r;
    int a = int'(ra) & amask(d);
    int w = int'(wa) & amask(d);
    if (has_zero(d) && a == 0) begin
      r.data = 32'd0;
      r.pend = 1'b0;
    end else if (we && w == a) begin
      r.data = wd & dmask(d);
      r.pend = 1'b0;
    end else begin
      r.data = mreg[d][a];
      r.pend = mpend[d][a];
    end
    return r;
  endfunction

  task automatic model_update(input int d, input logic we, input logic [2:0] wa,
                              input logic [31:0] wd, input logic re, input logic [2:0] ra);
    int w = int'(wa) & amask(d);
    int r = int'(ra) & amask(d);
    if (we && !(has_zero(d) && w == 0)) begin
      mreg[d][w]  = wd & dmask(d);
      mpend[d][w] = 1'b0;
    end
    if (re && !(has_zero(d) && r == 0)) mpend[d][r] = 1'b1;
  endtask

  task automatic model_clear();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 8; i++) begin
        mreg[d][i]  = 32'd0;
        mpend[d][i] = 1'b0;
      end
    q0.delete(); q1.delete(); q2.delete(); q3.delete();
    for (int p = 0; p < 4; p++) last_exp[p] = '0;
  endtask

  task automatic qpush(input int p, input exp_t e);
    case (p)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endtask

  function automatic int qsize(input int p);
    case (p)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  task automatic qpop(input int p, output exp_t e);
    case (p)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      2: e = q2.pop_front();
      default: e = q3.pop_front();
    endcase
  endtask

  // One clock of stimulus, applied at the falling edge for the next rising edge
  task automatic cycle(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                       input logic re, input logic [2:0] ra,
                       input logic e1, input logic [2:0] a1,
                       input logic e2, input logic [2:0] a2);
    @(negedge CLK);
    wr_en = we; wr_addr = wa; wr_data = wd;
    rsv_en = re; rsv_addr = ra;
    rd_en_1 = e1; rd_addr_1 = a1;
    rd_en_2 = e2; rd_addr_2 = a2;
    for (int d = 0; d < 2; d++) begin
      if (e1) qpush(d * 2,     model_read(d, a1, we, wa, wd));
      if (e2) qpush(d * 2 + 1, model_read(d, a2, we, wa, wd));
    end
    for (int d = 0; d < 2; d++) model_update(d, we, wa, wd, re, ra);
  endtask

  task automatic idle();
    cycle(1'b0, 3'd0, 32'd0, 1'b0, 3'd0, 1'b0, 3'd0, 1'b0, 3'd0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_a_data1"},  a_rd_data_1,  32'd0);
    chk({tag, "_a_data2"},  a_rd_data_2,  32'd0);
    chk({tag, "_a_valid1"}, a_rd_valid_1, 32'd0);
    chk({tag, "_a_valid2"}, a_rd_valid_2, 32'd0);
    chk({tag, "_a_pend1"},  a_rd_pend_1,  32'd0);
    chk({tag, "_a_pend2"},  a_rd_pend_2,  32'd0);
    chk({tag, "_b_data1"},  {24'd0, b_rd_data_1}, 32'd0);
    chk({tag, "_b_data2"},  {24'd0, b_rd_data_2}, 32'd0);
    chk({tag, "_b_valid1"}, b_rd_valid_1, 32'd0);
    chk({tag, "_b_valid2"}, b_rd_valid_2, 32'd0);
    chk({tag, "_b_pend1"},  b_rd_pend_1,  32'd0);
    chk({tag, "_b_pend2"},  b_rd_pend_2,  32'd0);
  endtask

  task automatic port_chk(input int p, input logic v, input logic [31:0] d, input logic pd);
    exp_t e;
    if (v) begin
      if (qsize(p) == 0) begin
        total++;
        bad++;
        $display("FAIL p%0d_valid: got unexpected valid, expected none at %0t", p, $time);
      end else begin
        qpop(p, e);
        last_exp[p] = e;
        chk($sformatf("p%0d_data", p), d, e.data);
        chk($sformatf("p%0d_pend", p), {31'd0, pd}, {31'd0, e.pend});
      end
    end else begin
      chk($sformatf("p%0d_hold_data", p), d, last_exp[p].data);
      chk($sformatf("p%0d_hold_pend", p), {31'd0, pd}, {31'd0, last_exp[p].pend});
    end
  endtask

  always @(negedge CLK) begin
    if (mon_on && RST_N === 1'b1) begin
      port_chk(0, a_rd_valid_1, a_rd_data_1, a_rd_pend_1);
      port_chk(1, a_rd_valid_2, a_rd_data_2, a_rd_pend_2);
      port_chk(2, b_rd_valid_1, {24'd0, b_rd_data_1}, b_rd_pend_1);
      port_chk(3, b_rd_valid_2, {24'd0, b_rd_data_2}, b_rd_pend_2);
    end
  end

  initial begin
    RST_N = 1'b0;
    wr_en = 0; wr_addr = 0; wr_data = 0; rsv_en = 0; rsv_addr = 0;
    rd_en_1 = 0; rd_addr_1 = 0; rd_en_2 = 0; rd_addr_2 = 0;
    model_clear();
    repeat (2) @(posedge CLK);
    #1;
    check_all_zero("init_rst");
    @(negedge CLK);
    RST_N = 1'b1;
    mon_on = 1;

    // Basic write / read
    cycle(1, 3'd0, 32'd256, 0, 0, 0, 0, 0, 0);
    cycle(1, 3'd1, 32'd128, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 3'd0, 1, 3'd1);
    idle();

    // Bypass
    cycle(1, 3'd2, 32'd5, 0, 0, 0, 0, 0, 0);
    cycle(1, 3'd2, 32'hDEAD_BEEF, 0, 0, 1, 3'd2, 0, 0);
    idle();

    // Scoreboard
    cycle(1, 3'd3, 32'd3, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 3'd3, 1, 3'd3, 0, 0);   // read sees pre-reserve state
    cycle(0, 0, 0, 0, 0, 1, 3'd3, 1, 3'd3);   // pending, old data
    cycle(1, 3'd3, 32'd7, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 3'd3, 0, 0);      // 7, not pending
    cycle(1, 3'd3, 32'd9, 1, 3'd3, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 3'd3, 1, 3'd3);   // 9, pending

    // Zero register
    cycle(1, 3'd0, 32'hFFFF, 1, 3'd0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 3'd0, 1, 3'd0);
    cycle(1, 3'd0, 32'h1234, 0, 0, 1, 3'd0, 1, 3'd0);
    idle();

    // Hold
    cycle(1, 3'd1, 32'd42, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 1, 3'd1, 0, 0);
    repeat (3) idle();

    // Reset mid-run with a read in flight on port 1
    cycle(1, 3'd5, 32'hA5, 1, 3'd6, 1, 3'd1, 1, 3'd5);
    @(posedge CLK);
    #2;
    chk("pre_rst_valid1", a_rd_valid_1, 32'd1);
    RST_N = 1'b0;
    #1;
    check_all_zero("mid_rst");
    model_clear();
    @(negedge CLK);
    wr_en = 0; rsv_en = 0; rd_en_1 = 0; rd_en_2 = 0;
    RST_N = 1'b1;
    for (int a = 0; a < 8; a++) cycle(0, 0, 0, 0, 0, 1, 3'(a), 1, 3'(7 - a));

    // Randomised traffic
    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 1)), 3'($urandom), $urandom,
            1'($urandom_range(0, 2) == 0), 3'($urandom),
            1'($urandom_range(0, 3) != 0), 3'($urandom),
            1'($urandom_range(0, 3) != 0), 3'($urandom));
    end
    repeat (2) idle();
    @(posedge CLK);
    #1;
    for (int p = 0; p < 4; p++) chk($sformatf("p%0d_drained", p), 32'(qsize(p)), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
